// File: rtl/ddr_phy_pkg.sv
// ddr_phy_pkg
//   Shared types and constants for the DDR3 PHY DQS lane controller.
//   - dqs_state_e : controller state encoding
//   - DQS_*/TRI_* : 4-bit OSERDES nibbles (bit 0 is serialised first)
//   - dly_addr_w  : width of a delay-table index for a given lane count
package ddr_phy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRE     = 3'd1,
      ST_BURST   = 3'd2,
      ST_POST    = 3'd3,
      ST_DLY_LD  = 3'd4,
      ST_DLY_SET = 3'd5
   } dqs_state_e;

   localparam logic [3:0] DQS_IDLE_D = 4'b0000;
   localparam logic [3:0] DQS_TOGGLE = 4'b0101;
   localparam logic [3:0] TRI_OFF    = 4'b1111;
   localparam logic [3:0] TRI_ON     = 4'b0000;

   // Two table entries per lane (data delay, tri delay); never narrower than 1 bit.
   function automatic int dly_addr_w(input int num_lanes);
      return (num_lanes < 2) ? 1 : $clog2(2 * num_lanes);
   endfunction

endpackage

// File: rtl/dqs_dly_table.sv
// dqs_dly_table
//   DEPTH x DLY_WIDTH delay register file with synchronous write,
//   registered read (enabled by re, holds otherwise) and synchronous clear.
//   Ports:
//     clk, rst            clock, synchronous active-high clear
//     we, waddr, wdata    write port (out-of-range addresses are dropped)
//     re, raddr           read enable / address
//     rdata               registered read data; returns the pre-write value
//                         when reading and writing the same entry in one cycle
module dqs_dly_table #(
   parameter int DEPTH     = 4,
   parameter int DLY_WIDTH = 8,
   parameter int AW        = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [DLY_WIDTH-1:0] wdata,
   input  logic                 re,
   input  logic [AW-1:0]        raddr,
   output logic [DLY_WIDTH-1:0] rdata
);

   logic [DLY_WIDTH-1:0] mem_q [DEPTH];
   logic [DLY_WIDTH-1:0] rdata_q;

   // Table storage and registered read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DLY_WIDTH{1'b0}};
         end
         rdata_q <= {DLY_WIDTH{1'b0}};
      end else begin
         if (we && (32'(waddr) < 32'(DEPTH))) begin
            mem_q[waddr] <= wdata;
         end
         if (re) begin
            rdata_q <= mem_q[raddr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dqs_burst_seq.sv
// dqs_burst_seq
//   DQS lane controller (clk_div domain) for a 4:1 OSERDES. Produces the
//   idle / preamble / toggle burst / postamble nibbles for NUM_LANES lanes and
//   sequences the per-lane data and tri delay loads followed by a common set.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     start, burst_len     burst request pulse and length (0 treated as 1)
//     dly_we/addr/wdata    delay table write (2*i = lane i data, 2*i+1 = tri)
//     dly_apply            request the delay load sequence
//     din, tin             per-lane data / tristate nibbles (tin 1 = high-Z)
//     dly_out, ld_dly      delay value and one-hot load strobe
//     set_dly              common set strobe
//     busy                 controller not idle
//   All outputs are registered and follow the state register by one cycle.
//   Optional macro DQS_BURST_SEQ_CONT_EN: a start seen in the last burst cycle
//   extends the burst seamlessly instead of running post/preamble.
module dqs_burst_seq
   import ddr_phy_pkg::*;
#(
   parameter int NUM_LANES  = 2,
   parameter int DLY_WIDTH  = 8,
   parameter int BLEN_WIDTH = 4,
   parameter int PRE_CYC    = 1,
   parameter int POST_CYC   = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [BLEN_WIDTH-1:0]               burst_len,
   input  logic                                dly_we,
   input  logic [dly_addr_w(NUM_LANES)-1:0]    dly_addr,
   input  logic [DLY_WIDTH-1:0]                dly_wdata,
   input  logic                                dly_apply,
   output logic [4*NUM_LANES-1:0]              din,
   output logic [4*NUM_LANES-1:0]              tin,
   output logic [DLY_WIDTH-1:0]                dly_out,
   output logic [2*NUM_LANES-1:0]              ld_dly,
   output logic                                set_dly,
   output logic                                busy
);

   localparam int AW   = dly_addr_w(NUM_LANES);
   localparam int NIDX = 2 * NUM_LANES;
   localparam int NW   = 4 * NUM_LANES;

   localparam logic [AW-1:0]         LAST_IDX = AW'(NIDX - 1);
   localparam logic [BLEN_WIDTH-1:0] CNT_ZERO = {BLEN_WIDTH{1'b0}};
   localparam logic [BLEN_WIDTH-1:0] CNT_ONE  = BLEN_WIDTH'(1);
   localparam logic [BLEN_WIDTH-1:0] PRE_LD   = BLEN_WIDTH'(PRE_CYC - 1);
   localparam logic [BLEN_WIDTH-1:0] POST_LD  = BLEN_WIDTH'(POST_CYC - 1);

   dqs_state_e            state_q, state_d;
   logic [BLEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [BLEN_WIDTH-1:0] len_q, len_d;
   logic [AW-1:0]         idx_q, idx_d;
   logic                  pend_q, pend_d;
   logic [NW-1:0]         din_q, din_d;
   logic [NW-1:0]         tin_q, tin_d;
   logic [NIDX-1:0]       ld_q, ld_d;
   logic                  set_q, set_d;
   logic                  busy_q, busy_d;
   logic [BLEN_WIDTH-1:0] start_len;

   assign start_len = (burst_len == CNT_ZERO) ? CNT_ONE : burst_len;

   // Next-state, counters and pending-apply flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d   = start_len;
               cnt_d   = PRE_LD;
               state_d = ST_PRE;
            end else if (dly_apply || pend_q) begin
               idx_d   = {AW{1'b0}};
               state_d = ST_DLY_LD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (cnt_q == CNT_ZERO) begin
               cnt_d   = len_q - CNT_ONE;
               state_d = ST_BURST;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_BURST: begin
            if (cnt_q == CNT_ZERO) begin
`ifdef DQS_BURST_SEQ_CONT_EN
               if (start) begin
                  // Back-to-back burst: keep toggling, no post/preamble.
                  len_d = start_len;
                  cnt_d = start_len - CNT_ONE;
               end else begin
                  cnt_d   = POST_LD;
                  state_d = ST_POST;
               end
`else
               cnt_d   = POST_LD;
               state_d = ST_POST;
`endif
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_POST: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DLY_LD: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_DLY_SET;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         ST_DLY_SET: begin
            pend_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // An apply that cannot start now is remembered; it also wins over the
      // clear in DLY_SET so a request arriving then still gets a full reload.
      if (dly_apply && ((state_q != ST_IDLE) || start)) begin
         pend_d = 1'b1;
      end else begin
         pend_d = pend_d;
      end
   end

   // Output pattern decode from the current state.
   always_comb begin
      din_d  = {NUM_LANES{DQS_IDLE_D}};
      tin_d  = {NUM_LANES{TRI_OFF}};
      ld_d   = {NIDX{1'b0}};
      set_d  = 1'b0;
      busy_d = (state_q != ST_IDLE);
      case (state_q)
         ST_PRE, ST_POST: begin
            tin_d = {NUM_LANES{TRI_ON}};
         end
         ST_BURST: begin
            din_d = {NUM_LANES{DQS_TOGGLE}};
            tin_d = {NUM_LANES{TRI_ON}};
         end
         ST_DLY_LD: begin
            ld_d = NIDX'(1) << idx_q;
         end
         ST_DLY_SET: begin
            set_d = 1'b1;
         end
         default: begin
            busy_d = busy_d;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ZERO;
         len_q   <= CNT_ZERO;
         idx_q   <= {AW{1'b0}};
         pend_q  <= 1'b0;
         din_q   <= {NW{1'b0}};
         tin_q   <= {NW{1'b1}};
         ld_q    <= {NIDX{1'b0}};
         set_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         din_q   <= din_d;
         tin_q   <= tin_d;
         ld_q    <= ld_d;
         set_q   <= set_d;
         busy_q  <= busy_d;
      end
   end

   // Registered read lines dly_out up with the ld_dly strobe of the same index.
   dqs_dly_table #(
      .DEPTH     (NIDX),
      .DLY_WIDTH (DLY_WIDTH),
      .AW        (AW)
   ) u_tbl (
      .clk   (clk),
      .rst   (rst),
      .we    (dly_we),
      .waddr (dly_addr),
      .wdata (dly_wdata),
      .re    (state_q == ST_DLY_LD),
      .raddr (idx_q),
      .rdata (dly_out)
   );

   assign din     = din_q;
   assign tin     = tin_q;
   assign ld_dly  = ld_q;
   assign set_dly = set_q;
   assign busy    = busy_q;

endmodule
